execute_stage_md: RTL and testbench

- Parametrised next-generation execute stage for the pipelined RISC-V core; sits between the ID/EX and EX/MEM registers and owns the EX/MEM register.
- Adds over the current execute stage:
  - configurable XLEN;
  - full RV32I ALU op set;
  - the six RV branch conditions plus jumps;
  - single-cycle MUL/MULH;
  - a multi-cycle radix-2 divider that stalls the front of the pipe through a handshake with the hazard unit.

---
 rtl/exec_pkg.sv | 63 ++++++
 rtl/div_seq.sv | 157 +++++++++++++++
 rtl/execute_stage_md.sv | 247 ++++++++++++++++++++++++
 tb/tb_execute_stage_md.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_pkg
//  Description : Shared encodings for the execute stage: ALU operation codes,
//                branch condition codes, forwarding selects and the divider
//                state encoding, plus small op-classification helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package exec_pkg;

    // ALU operation codes carried on ALUControlE
    localparam logic [4:0] c_alu_add  = 5'd0;
    localparam logic [4:0] c_alu_sub  = 5'd1;
    localparam logic [4:0] c_alu_and  = 5'd2;
    localparam logic [4:0] c_alu_or   = 5'd3;
    localparam logic [4:0] c_alu_xor  = 5'd4;
    localparam logic [4:0] c_alu_sll  = 5'd5;
    localparam logic [4:0] c_alu_srl  = 5'd6;
    localparam logic [4:0] c_alu_sra  = 5'd7;
    localparam logic [4:0] c_alu_slt  = 5'd8;
    localparam logic [4:0] c_alu_sltu = 5'd9;
    localparam logic [4:0] c_alu_mul  = 5'd10;
    localparam logic [4:0] c_alu_mulh = 5'd11;
    localparam logic [4:0] c_alu_div  = 5'd12;
    localparam logic [4:0] c_alu_divu = 5'd13;
    localparam logic [4:0] c_alu_rem  = 5'd14;
    localparam logic [4:0] c_alu_remu = 5'd15;

    // Branch conditions carried on BrFuncE (funct3 encoding)
    localparam logic [2:0] c_br_beq  = 3'b000;
    localparam logic [2:0] c_br_bne  = 3'b001;
    localparam logic [2:0] c_br_blt  = 3'b100;
    localparam logic [2:0] c_br_bge  = 3'b101;
    localparam logic [2:0] c_br_bltu = 3'b110;
    localparam logic [2:0] c_br_bgeu = 3'b111;

    // Forwarding selects; 2'b11 falls back to the register value
    localparam logic [1:0] c_fwd_reg = 2'b00;
    localparam logic [1:0] c_fwd_wb  = 2'b01;
    localparam logic [1:0] c_fwd_mem = 2'b10;

    // Divider sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    function automatic logic is_div_op(input logic [4:0] alu_op);
        return (alu_op == c_alu_div)  || (alu_op == c_alu_divu) ||
               (alu_op == c_alu_rem)  || (alu_op == c_alu_remu);
    endfunction

    function automatic logic is_signed_div_op(input logic [4:0] alu_op);
        return (alu_op == c_alu_div) || (alu_op == c_alu_rem);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] alu_op);
        return (alu_op == c_alu_rem) || (alu_op == c_alu_remu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Radix-2 restoring sequential divider. One quotient bit per
//                cycle, XLEN iterations, fixed latency regardless of operand
//                values. Operands are captured on acceptance so the caller
//                may change its inputs while the division runs.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk          rising-edge clock
//    rst          asynchronous reset, active low
//    i_start      request a division this cycle
//    i_abort      cancel a request or a division in flight
//    i_is_signed  treat operands as two's complement
//    i_want_rem   return remainder instead of quotient
//    i_dividend   dividend
//    i_divisor    divisor
//    o_accept     request accepted this cycle (operands captured at edge)
//    o_stall      divider occupied; upstream must hold
//    o_done       final result valid on o_result this cycle
//    o_result     sign-corrected quotient or remainder
//
//  DIV_CNT_W must satisfy 2**DIV_CNT_W > XLEN.
// ============================================================================
module div_seq
    import exec_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_is_signed,
    input  logic            i_want_rem,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_accept,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    div_state_t             r_state;
    div_state_t             w_state_next;

    logic [XLEN-1:0]        r_quo;      // dividend shifts out, quotient shifts in
    logic [XLEN-1:0]        r_rem;      // partial remainder
    logic [XLEN-1:0]        r_dvs;      // divisor magnitude
    logic [DIV_CNT_W-1:0]   r_cnt;
    logic                   r_q_neg;
    logic                   r_r_neg;
    logic                   r_want_rem;

    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [XLEN-1:0]        w_a_mag;
    logic [XLEN-1:0]        w_b_mag;
    logic [XLEN:0]          w_shift;
    logic [XLEN:0]          w_diff;
    logic [XLEN-1:0]        w_q_fix;
    logic [XLEN-1:0]        w_r_fix;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_accept     = 1'b0;
        o_stall      = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    o_accept     = 1'b1;
                    o_stall      = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                o_stall = 1'b1;
                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand conditioning: divide magnitudes, fix signs at the end
    // ------------------------------------------------------------------
    assign w_a_neg = i_is_signed & i_dividend[XLEN-1];
    assign w_b_neg = i_is_signed & i_divisor[XLEN-1];
    assign w_a_mag = w_a_neg ? -i_dividend : i_dividend;
    assign w_b_mag = w_b_neg ? -i_divisor  : i_divisor;

    // The partial remainder is always < divisor, so a shift never loses a
    // bit; the top bit of the difference acts as the borrow.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_cnt      <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_want_rem <= 1'b0;
        end else if (o_accept) begin
            r_quo      <= w_a_mag;
            r_rem      <= '0;
            r_dvs      <= w_b_mag;
            r_cnt      <= DIV_CNT_W'(XLEN - 1);
            // Divide-by-zero keeps the all-ones quotient unnegated.
            r_q_neg    <= (w_a_neg ^ w_b_neg) & (i_divisor != '0);
            // Remainder takes the dividend's sign; this also makes x/0
            // return the dividend.
            r_r_neg    <= w_a_neg;
            r_want_rem <= i_want_rem;
        end else if (r_state == S_BUSY) begin
            r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
            r_rem <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - DIV_CNT_W'(1);
            end
        end
    end

    // MIN/-1 falls out naturally: magnitude quotient 2**(XLEN-1) with a
    // positive sign is already the most-negative bit pattern.
    assign w_q_fix  = r_q_neg ? -r_quo : r_quo;
    assign w_r_fix  = r_r_neg ? -r_rem : r_rem;
    assign o_result = r_want_rem ? w_r_fix : w_q_fix;

endmodule
`default_nettype wire

// File: rtl/execute_stage_md.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage_md
//  Description : Execute stage of the pipelined RISC-V core. Operand
//                forwarding, RV32I ALU, MUL/MULH, branch resolution, a
//                multi-cycle divider handshaking with the hazard unit, and
//                the EX/MEM pipeline register.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, rst                    clock; asynchronous active-low reset
//    ValidE, FlushE              instruction valid / squash (aborts divide)
//    RegWriteE, MemWriteE,
//    ResultSrcE                  control bits forwarded to MEM
//    ALUSrcE                     1 selects Imm_Ext_E as Src_B
//    BranchE, JumpE, BrFuncE     branch/jump control and condition
//    ALUControlE                 operation code (exec_pkg)
//    RD1_E, RD2_E, Imm_Ext_E,
//    PCE, PCPlus4E               operands and PC values
//    RD_E                        destination register
//    ForwardA_E, ForwardB_E      forwarding selects
//    ResultW                     writeback forwarding value
//    StallE                      EX busy; hazard unit holds the front end
//    PCSrcE, PCTargetE           fetch redirect and target
//    RegWriteM .. ALU_ResultM    EX/MEM register outputs
// ============================================================================
module execute_stage_md
    import exec_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RADDR_W   = 5,
    parameter int DIV_CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ValidE,
    input  logic               FlushE,
    input  logic               RegWriteE,
    input  logic               MemWriteE,
    input  logic               ResultSrcE,
    input  logic               ALUSrcE,
    input  logic               BranchE,
    input  logic               JumpE,
    input  logic [2:0]         BrFuncE,
    input  logic [4:0]         ALUControlE,
    input  logic [XLEN-1:0]    RD1_E,
    input  logic [XLEN-1:0]    RD2_E,
    input  logic [XLEN-1:0]    Imm_Ext_E,
    input  logic [XLEN-1:0]    PCE,
    input  logic [XLEN-1:0]    PCPlus4E,
    input  logic [RADDR_W-1:0] RD_E,
    input  logic [1:0]         ForwardA_E,
    input  logic [1:0]         ForwardB_E,
    input  logic [XLEN-1:0]    ResultW,
    output logic               StallE,
    output logic               PCSrcE,
    output logic [XLEN-1:0]    PCTargetE,
    output logic               RegWriteM,
    output logic               MemWriteM,
    output logic               ResultSrcM,
    output logic [RADDR_W-1:0] RD_M,
    output logic [XLEN-1:0]    PCPlus4M,
    output logic [XLEN-1:0]    WriteDataM,
    output logic [XLEN-1:0]    ALU_ResultM
);

    localparam int C_SHAMT_W = $clog2(XLEN);

    logic [XLEN-1:0]      w_src_a;
    logic [XLEN-1:0]      w_fwd_b;
    logic [XLEN-1:0]      w_src_b;
    logic [C_SHAMT_W-1:0] w_shamt;
    logic [2*XLEN-1:0]    w_a_ext;
    logic [2*XLEN-1:0]    w_b_ext;
    logic [2*XLEN-1:0]    w_prod;
    logic                 w_lt_s;
    logic                 w_lt_u;
    logic [XLEN-1:0]      w_alu;
    logic                 w_br_cond;
    logic                 w_bubble;

    logic                 w_div_accept;
    logic                 w_div_stall;
    logic                 w_div_done;
    logic [XLEN-1:0]      w_div_result;

    // Control fields of the divide in flight; ID/EX keeps its contents
    // while stalled, but capturing them here keeps the result independent
    // of whatever the front end presents in the completion cycle.
    logic                 r_lat_regwrite;
    logic                 r_lat_memwrite;
    logic                 r_lat_resultsrc;
    logic [RADDR_W-1:0]   r_lat_rd;
    logic [XLEN-1:0]      r_lat_pcplus4;
    logic [XLEN-1:0]      r_lat_wdata;

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] reg_val,
        input logic [XLEN-1:0] wb_val,
        input logic [XLEN-1:0] mem_val
    );
        case (sel)
            c_fwd_wb:  return wb_val;
            c_fwd_mem: return mem_val;
            default:   return reg_val;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    assign w_src_a = fwd_sel(ForwardA_E, RD1_E, ResultW, ALU_ResultM);
    assign w_fwd_b = fwd_sel(ForwardB_E, RD2_E, ResultW, ALU_ResultM);
    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;
    assign w_shamt = w_src_b[C_SHAMT_W-1:0];

    // One signed multiplier serves both MUL (low half) and MULH (high half)
    assign w_a_ext = {{XLEN{w_src_a[XLEN-1]}}, w_src_a};
    assign w_b_ext = {{XLEN{w_src_b[XLEN-1]}}, w_src_b};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_lt_s  = $signed(w_src_a) < $signed(w_src_b);
    assign w_lt_u  = w_src_a < w_src_b;

    always_comb begin
        w_alu = '0;
        case (ALUControlE)
            c_alu_add:  w_alu = w_src_a + w_src_b;
            c_alu_sub:  w_alu = w_src_a - w_src_b;
            c_alu_and:  w_alu = w_src_a & w_src_b;
            c_alu_or:   w_alu = w_src_a | w_src_b;
            c_alu_xor:  w_alu = w_src_a ^ w_src_b;
            c_alu_sll:  w_alu = w_src_a << w_shamt;
            c_alu_srl:  w_alu = w_src_a >> w_shamt;
            c_alu_sra:  w_alu = $unsigned($signed(w_src_a) >>> w_shamt);
            c_alu_slt:  w_alu = {{(XLEN-1){1'b0}}, w_lt_s};
            c_alu_sltu: w_alu = {{(XLEN-1){1'b0}}, w_lt_u};
            c_alu_mul:  w_alu = w_prod[XLEN-1:0];
            c_alu_mulh: w_alu = w_prod[2*XLEN-1:XLEN];
            default:    w_alu = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Branch resolution: compares against forwarded B, never the immediate
    // ------------------------------------------------------------------
    always_comb begin
        w_br_cond = 1'b0;
        case (BrFuncE)
            c_br_beq:  w_br_cond = (w_src_a == w_fwd_b);
            c_br_bne:  w_br_cond = (w_src_a != w_fwd_b);
            c_br_blt:  w_br_cond = $signed(w_src_a) <  $signed(w_fwd_b);
            c_br_bge:  w_br_cond = $signed(w_src_a) >= $signed(w_fwd_b);
            c_br_bltu: w_br_cond = w_src_a <  w_fwd_b;
            c_br_bgeu: w_br_cond = w_src_a >= w_fwd_b;
            default:   w_br_cond = 1'b0;
        endcase
    end

    assign PCSrcE    = ValidE & ~FlushE & (JumpE | (BranchE & w_br_cond));
    assign PCTargetE = PCE + Imm_Ext_E;

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    div_seq #(
        .XLEN      (XLEN),
        .DIV_CNT_W (DIV_CNT_W)
    ) u_div_seq (
        .clk         (clk),
        .rst         (rst),
        .i_start     (ValidE & is_div_op(ALUControlE)),
        .i_abort     (FlushE),
        .i_is_signed (is_signed_div_op(ALUControlE)),
        .i_want_rem  (is_rem_op(ALUControlE)),
        .i_dividend  (w_src_a),
        .i_divisor   (w_src_b),
        .o_accept    (w_div_accept),
        .o_stall     (w_div_stall),
        .o_done      (w_div_done),
        .o_result    (w_div_result)
    );

    assign StallE = w_div_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lat_regwrite  <= 1'b0;
            r_lat_memwrite  <= 1'b0;
            r_lat_resultsrc <= 1'b0;
            r_lat_rd        <= '0;
            r_lat_pcplus4   <= '0;
            r_lat_wdata     <= '0;
        end else if (w_div_accept) begin
            r_lat_regwrite  <= RegWriteE;
            r_lat_memwrite  <= MemWriteE;
            r_lat_resultsrc <= ResultSrcE;
            r_lat_rd        <= RD_E;
            r_lat_pcplus4   <= PCPlus4E;
            r_lat_wdata     <= w_fwd_b;
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM register: never held; stalls and squashes insert bubbles
    // ------------------------------------------------------------------
    assign w_bubble = ~ValidE | FlushE | w_div_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else if (w_div_done && !FlushE) begin
            RegWriteM   <= r_lat_regwrite;
            MemWriteM   <= r_lat_memwrite;
            ResultSrcM  <= r_lat_resultsrc;
            RD_M        <= r_lat_rd;
            PCPlus4M    <= r_lat_pcplus4;
            WriteDataM  <= r_lat_wdata;
            ALU_ResultM <= w_div_result;
        end else if (w_bubble) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= w_fwd_b;
            ALU_ResultM <= w_alu;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage_md.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_stage_md
//  Description : Directed self-checking bench for execute_stage_md. Expected
//                EX/MEM contents are queued when an instruction is driven and
//                compared when the register has captured it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_execute_stage_md;
    import exec_pkg::*;

    localparam int XLEN      = 32;
    localparam int RADDR_W   = 5;
    localparam int DIV_CNT_W = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               ValidE, FlushE, RegWriteE, MemWriteE, ResultSrcE;
    logic               ALUSrcE, BranchE, JumpE;
    logic [2:0]         BrFuncE;
    logic [4:0]         ALUControlE;
    logic [XLEN-1:0]    RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [RADDR_W-1:0] RD_E;
    logic [1:0]         ForwardA_E, ForwardB_E;
    logic               StallE, PCSrcE;
    logic [XLEN-1:0]    PCTargetE;
    logic               RegWriteM, MemWriteM, ResultSrcM;
    logic [RADDR_W-1:0] RD_M;
    logic [XLEN-1:0]    PCPlus4M, WriteDataM, ALU_ResultM;

    always #5 clk = ~clk;

    execute_stage_md #(
        .XLEN(XLEN), .RADDR_W(RADDR_W), .DIV_CNT_W(DIV_CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .ValidE(ValidE), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE), .BrFuncE(BrFuncE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E),
        .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
        .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM)
    );

    typedef struct {
        string       tag;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd, input logic rw, input logic mw);
        sb.push_back('{tag, alu, wd, rd, rw, mw});
    endtask

    task automatic pop_check();
        exp_t e;
        check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, "_alu"}, ALU_ResultM, e.alu);
            check({e.tag, "_wdata"}, WriteDataM, e.wd);
            check({e.tag, "_rd"}, {27'b0, RD_M}, {27'b0, e.rd});
            check({e.tag, "_regwrite"}, {31'b0, RegWriteM}, {31'b0, e.rw});
            check({e.tag, "_memwrite"}, {31'b0, MemWriteM}, {31'b0, e.mw});
        end
    endtask

    task automatic drive(input logic valid, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic alusrc,
                         input logic [4:0] rd, input logic rw);
        ValidE = valid;  ALUControlE = op; RD1_E = a; RD2_E = b; Imm_Ext_E = imm;
        ALUSrcE = alusrc; RD_E = rd; RegWriteE = rw; MemWriteE = 1'b0; ResultSrcE = 1'b0;
        FlushE = 1'b0; BranchE = 1'b0; JumpE = 1'b0; BrFuncE = 3'b000;
        ForwardA_E = 2'b00; ForwardB_E = 2'b00; PCE = 32'h100; PCPlus4E = 32'h104;
    endtask

    task automatic alu_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_v);
        drive(1'b1, op, a, b, 32'h0, 1'b0, 5'd9, 1'b1);
        push(tag, exp_v, b, 5'd9, 1'b1, 1'b0);
        tick();
        pop_check();
    endtask

    task automatic br_check(input string tag, input logic [2:0] func, input logic [31:0] a,
                            input logic [31:0] b, input logic exp_v);
        drive(1'b1, c_alu_sub, a, b, 32'h8, 1'b0, 5'd0, 1'b0);
        BranchE = 1'b1;
        BrFuncE = func;
        #1;
        check(tag, {31'b0, PCSrcE}, {31'b0, exp_v});
    endtask

    // Divisor arrives through WB forwarding and is disturbed mid-stall.
    task automatic run_div(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_v);
        int stall_cycles;
        drive(1'b1, op, a, 32'hCAFE_F00D, 32'h0, 1'b0, 5'd7, 1'b1);
        ForwardB_E = 2'b01;
        ResultW    = b;
        push(tag, exp_v, b, 5'd7, 1'b1, 1'b0);
        #1;
        stall_cycles = 0;
        for (int guard = 0; guard < 100 && StallE; guard++) begin
            stall_cycles++;
            if (guard == 4) ResultW = ~b;
            tick();
        end
        check({tag, "_stall_len"}, stall_cycles, 32'd33);
        tick();
        ValidE = 1'b0; RegWriteE = 1'b0; ForwardB_E = 2'b00;
        pop_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, c_alu_add, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        ResultW = 32'h0;

        // Reset state
        tick(); tick();
        check("rst_alu", ALU_ResultM, 32'h0);
        check("rst_regwrite", {31'b0, RegWriteM}, 32'h0);
        check("rst_stall", {31'b0, StallE}, 32'h0);
        check("rst_rd", {27'b0, RD_M}, 32'h0);
        rst = 1'b1;
        tick();

        // ADD with register operands
        drive(1'b1, c_alu_add, 32'h10, 32'h20, 32'h0, 1'b0, 5'd3, 1'b1);
        push("add", 32'h30, 32'h20, 5'd3, 1'b1, 1'b0);
        #1;
        check("add_stall", {31'b0, StallE}, 32'h0);
        tick();
        pop_check();

        // SUB: A from MEM (0x30), B from WB (0x5)
        drive(1'b1, c_alu_sub, 32'hDEAD, 32'hBEEF, 32'h0, 1'b0, 5'd4, 1'b1);
        ForwardA_E = 2'b10; ForwardB_E = 2'b01; ResultW = 32'h5;
        push("fwd_sub", 32'h2B, 32'h5, 5'd4, 1'b1, 1'b0);
        tick();
        pop_check();

        // ForwardA = 11 falls back to RD1_E
        drive(1'b1, c_alu_add, 32'h100, 32'h1, 32'h0, 1'b0, 5'd5, 1'b1);
        ForwardA_E = 2'b11;
        push("fwd11", 32'h101, 32'h1, 5'd5, 1'b1, 1'b0);
        tick();
        pop_check();

        // Immediate operand, store control pass-through
        drive(1'b1, c_alu_add, 32'd10, 32'h1234, 32'hFFFF_FFFF, 1'b1, 5'd6, 1'b0);
        MemWriteE = 1'b1;
        push("addi_sw", 32'd9, 32'h1234, 5'd6, 1'b0, 1'b1);
        tick();
        pop_check();

        // Single-cycle op table
        alu_op("and",  c_alu_and,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
        alu_op("or",   c_alu_or,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
        alu_op("xor",  c_alu_xor,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        alu_op("sll",  c_alu_sll,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010);
        alu_op("srl",  c_alu_srl,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
        alu_op("sra",  c_alu_sra,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
        alu_op("slt",  c_alu_slt,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
        alu_op("sltu", c_alu_sltu, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        alu_op("sub",  c_alu_sub,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE);
        alu_op("mul",  c_alu_mul,  32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD);
        alu_op("mulh_neg", c_alu_mulh, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF);
        alu_op("mulh_pos", c_alu_mulh, 32'h4000_0000, 32'h0000_0004, 32'h0000_0001);

        // Bubbles: invalid and flushed instructions
        drive(1'b0, c_alu_add, 32'h1, 32'h2, 32'h0, 1'b0, 5'd8, 1'b1);
        push("invalid", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        pop_check();
        drive(1'b1, c_alu_add, 32'h1, 32'h2, 32'h0, 1'b0, 5'd8, 1'b1);
        FlushE = 1'b1;
        push("flush", 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        pop_check();

        // Branches
        br_check("blt_taken", c_br_blt, 32'hFFFF_FFFF, 32'h1, 1'b1);
        check("blt_target", PCTargetE, 32'h108);
        br_check("bltu_not", c_br_bltu, 32'hFFFF_FFFF, 32'h1, 1'b0);
        br_check("bge_taken", c_br_bge, 32'h1, 32'hFFFF_FFFF, 1'b1);
        br_check("bgeu_not", c_br_bgeu, 32'h1, 32'hFFFF_FFFF, 1'b0);
        br_check("beq_taken", c_br_beq, 32'h55, 32'h55, 1'b1);
        br_check("bne_not", c_br_bne, 32'h55, 32'h55, 1'b0);
        br_check("blt_imm", c_br_blt, 32'h5, 32'h6, 1'b1);
        ALUSrcE = 1'b1; #1;
        check("br_uses_fwd_b", {31'b0, PCSrcE}, 32'h1);
        JumpE = 1'b1; BranchE = 1'b0; #1;
        check("jump", {31'b0, PCSrcE}, 32'h1);
        FlushE = 1'b1; #1;
        check("jump_flushed", {31'b0, PCSrcE}, 32'h0);
        drive(1'b0, c_alu_add, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        tick();

        // Divider
        run_div("div_neg",   c_alu_div,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD);
        run_div("rem_neg",   c_alu_rem,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF);
        run_div("div_negb",  c_alu_div,  32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_div("rem_negb",  c_alu_rem,  32'h7, 32'hFFFF_FFFE, 32'h1);
        run_div("divu",      c_alu_divu, 32'd100, 32'd7, 32'd14);
        run_div("remu",      c_alu_remu, 32'd100, 32'd7, 32'd2);
        run_div("divu_by0",  c_alu_divu, 32'd5, 32'h0, 32'hFFFF_FFFF);
        run_div("rem_by0",   c_alu_rem,  32'd5, 32'h0, 32'd5);
        run_div("div_negby0", c_alu_div, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFF);
        run_div("rem_negby0", c_alu_rem, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB);
        run_div("div_ovf",   c_alu_div,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("rem_ovf",   c_alu_rem,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Back-to-back: instruction right after a divide completes normally
        alu_op("after_div", c_alu_add, 32'h7, 32'h8, 32'hF);

        // Abort via FlushE in the tenth BUSY cycle
        drive(1'b1, c_alu_div, 32'd100, 32'd7, 32'h0, 1'b0, 5'd12, 1'b1);
        #1;
        check("abort_issue_stall", {31'b0, StallE}, 32'h1);
        for (int i = 0; i < 10; i++) tick();
        check("abort_busy_stall", {31'b0, StallE}, 32'h1);
        FlushE = 1'b1;
        tick();
        drive(1'b0, c_alu_add, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        check("abort_stall_low", {31'b0, StallE}, 32'h0);
        check("abort_regwrite", {31'b0, RegWriteM}, 32'h0);
        begin
            logic seen_write;
            seen_write = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (RegWriteM || StallE) seen_write = 1'b1;
            end
            check("abort_no_result", {31'b0, seen_write}, 32'h0);
        end

        // Asynchronous reset in the middle of a divide
        drive(1'b1, c_alu_div, 32'd100, 32'd7, 32'h0, 1'b0, 5'd12, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        check("rstmid_busy", {31'b0, StallE}, 32'h1);
        rst = 1'b0;
        ValidE = 1'b0;
        #1;
        check("rstmid_stall", {31'b0, StallE}, 32'h0);
        check("rstmid_alu", ALU_ResultM, 32'h0);
        check("rstmid_regwrite", {31'b0, RegWriteM}, 32'h0);
        tick();
        rst = 1'b1;
        drive(1'b1, c_alu_add, 32'h21, 32'h21, 32'h0, 1'b0, 5'd2, 1'b1);
        push("rstmid_add", 32'h42, 32'h21, 5'd2, 1'b1, 1'b0);
        #1;
        check("rstmid_add_stall", {31'b0, StallE}, 32'h0);
        tick();
        pop_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
